// File: rtl/router_pkg.sv
// Shared router types and defaults used by the VC input buffer and its FIFOs.
package router_pkg;

  localparam int FLIT_WIDTH_DEFAULT = 32;
  localparam int NUM_VCS_DEFAULT    = 3;

  typedef logic [$clog2(NUM_VCS_DEFAULT)-1:0] vc_idx_t;
  typedef logic [FLIT_WIDTH_DEFAULT-1:0]      flit_t;

  // True when exactly one bit of the (zero-extended) vector is set.
  function automatic logic is_onehot(input logic [31:0] vec);
    return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO for one virtual channel; combinational read of the head entry.
module fifo_sync #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Payload storage is deliberately not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vc_input_buffer.sv
// Per-port virtual-channel input buffer feeding the switch arbiter.
// Optional sticky error output enabled by defining VC_BUF_OVERFLOW_CHECK_EN.
module vc_input_buffer
  import router_pkg::*;
#(
  parameter  int NUM_VCS    = 3,
  parameter  int BUF_DEPTH  = 4,
  parameter  int FLIT_WIDTH = FLIT_WIDTH_DEFAULT,
  localparam int VCW        = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int CW         = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flit_in_valid,
  input  logic [VCW-1:0]        flit_in_vc,
  input  logic [FLIT_WIDTH-1:0] flit_in,
  output logic [NUM_VCS-1:0]    requests,
  input  logic [NUM_VCS-1:0]    grants,
  output logic                  flit_out_valid,
  output logic [VCW-1:0]        flit_out_vc,
  output logic [FLIT_WIDTH-1:0] flit_out,
  output logic                  credit_out_valid,
  output logic [VCW-1:0]        credit_out_vc
`ifdef VC_BUF_OVERFLOW_CHECK_EN
  ,
  output logic                  error
`endif
);

  logic [NUM_VCS-1:0]    push_vec;
  logic [NUM_VCS-1:0]    pop_vec;
  logic [NUM_VCS-1:0]    full_vec;
  logic [NUM_VCS-1:0]    empty_vec;
  logic [FLIT_WIDTH-1:0] rd_data [NUM_VCS];
  logic [CW-1:0]         vc_count [NUM_VCS];
  logic                  grant_onehot;
  logic                  pop_any;
  logic [VCW-1:0]        pop_idx;
  logic [FLIT_WIDTH-1:0] pop_data;

  assign grant_onehot = is_onehot(32'(grants));

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    // An out-of-range flit_in_vc never matches any v, so it is dropped here.
    assign push_vec[v] = flit_in_valid && (flit_in_vc == VCW'(v)) && !full_vec[v];
    assign pop_vec[v]  = grant_onehot && grants[v] && !empty_vec[v];
    assign requests[v] = (vc_count[v] != '0);

    fifo_sync #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (FLIT_WIDTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push_vec[v]),
      .pop     (pop_vec[v]),
      .wr_data (flit_in),
      .rd_data (rd_data[v]),
      .full    (full_vec[v]),
      .empty   (empty_vec[v]),
      .count   (vc_count[v])
    );
  end

  // pop_vec has at most one bit set, so a priority loop acts as a plain mux.
  always_comb begin
    pop_any  = 1'b0;
    pop_idx  = '0;
    pop_data = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (pop_vec[v]) begin
        pop_any  = 1'b1;
        pop_idx  = VCW'(v);
        pop_data = rd_data[v];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flit_out_valid   <= 1'b0;
      flit_out_vc      <= '0;
      flit_out         <= '0;
      credit_out_valid <= 1'b0;
      credit_out_vc    <= '0;
    end else begin
      flit_out_valid   <= pop_any;
      credit_out_valid <= pop_any;
      if (pop_any) begin
        flit_out      <= pop_data;
        flit_out_vc   <= pop_idx;
        credit_out_vc <= pop_idx;
      end
    end
  end

`ifdef VC_BUF_OVERFLOW_CHECK_EN
  logic push_dropped;
  logic grant_bad;

  assign push_dropped = flit_in_valid && (push_vec == '0);
  assign grant_bad    = (grants != '0) && !grant_onehot;

  // Sticky until reset so that a single glitch is never missed by software.
  always_ff @(posedge clk) begin
    if (reset) begin
      error <= 1'b0;
    end else if (push_dropped || grant_bad) begin
      error <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && (push_dropped || grant_bad)) begin
      $error("vc_input_buffer: dropped push or malformed grant");
    end
  end
`endif

endmodule

// File: tb/tb_vc_input_buffer.sv
// Directed self-checking bench for vc_input_buffer (3 VCs, depth 4, 32-bit flits).
module tb_vc_input_buffer;

  logic        clk;
  logic        reset;
  logic        flit_in_valid;
  logic [1:0]  flit_in_vc;
  logic [31:0] flit_in;
  logic [2:0]  requests;
  logic [2:0]  grants;
  logic        flit_out_valid;
  logic [1:0]  flit_out_vc;
  logic [31:0] flit_out;
  logic        credit_out_valid;
  logic [1:0]  credit_out_vc;
`ifdef VC_BUF_OVERFLOW_CHECK_EN
  logic        error;
`endif

  int checks = 0;
  int errors = 0;

  vc_input_buffer #(
    .NUM_VCS    (3),
    .BUF_DEPTH  (4),
    .FLIT_WIDTH (32)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .flit_in_valid    (flit_in_valid),
    .flit_in_vc       (flit_in_vc),
    .flit_in          (flit_in),
    .requests         (requests),
    .grants           (grants),
    .flit_out_valid   (flit_out_valid),
    .flit_out_vc      (flit_out_vc),
    .flit_out         (flit_out),
    .credit_out_valid (credit_out_valid),
    .credit_out_vc    (credit_out_vc)
`ifdef VC_BUF_OVERFLOW_CHECK_EN
    ,
    .error            (error)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge happen, then return inputs to idle.
  task automatic applyStimulus(input logic pv, input logic [1:0] pvc,
                               input logic [31:0] pd, input logic [2:0] g);
    flit_in_valid = pv;
    flit_in_vc    = pvc;
    flit_in       = pd;
    grants        = g;
    @(posedge clk);
    #1;
    flit_in_valid = 1'b0;
    flit_in_vc    = 2'd0;
    flit_in       = 32'd0;
    grants        = 3'b000;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkPop(input string tag, input logic [1:0] vc,
                          input logic [31:0] data);
    checkOutput({tag, "_valid"}, 32'(flit_out_valid), 32'd1);
    checkOutput({tag, "_data"}, flit_out, data);
    checkOutput({tag, "_vc"}, 32'(flit_out_vc), 32'(vc));
    checkOutput({tag, "_cvalid"}, 32'(credit_out_valid), 32'd1);
    checkOutput({tag, "_cvc"}, 32'(credit_out_vc), 32'(vc));
  endtask

  task automatic checkNoPop(input string tag);
    checkOutput({tag, "_valid"}, 32'(flit_out_valid), 32'd0);
    checkOutput({tag, "_cvalid"}, 32'(credit_out_valid), 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    flit_in_valid = 1'b0;
    flit_in_vc    = 2'd0;
    flit_in       = 32'd0;
    grants        = 3'b000;
    applyStimulus(1'b0, 2'd0, 32'd0, 3'b000);
    applyStimulus(1'b0, 2'd0, 32'd0, 3'b000);
    checkOutput("rst_requests", 32'(requests), 32'd0);
    checkOutput("rst_flit_out", flit_out, 32'd0);
    checkNoPop("rst");
`ifdef VC_BUF_OVERFLOW_CHECK_EN
    checkOutput("rst_error", 32'(error), 32'd0);
`endif
    reset = 1'b0;

    // One flit per VC, then pop VC0
    applyStimulus(1'b1, 2'd0, 32'hA0, 3'b000);
    applyStimulus(1'b1, 2'd1, 32'hB1, 3'b000);
    applyStimulus(1'b1, 2'd2, 32'hC2, 3'b000);
    checkOutput("req_all", 32'(requests), 32'h7);
    checkNoPop("no_grant_yet");
    applyStimulus(1'b0, 2'd0, 32'd0, 3'b001);
    checkPop("pop_vc0", 2'd0, 32'hA0);
    checkOutput("req_after_vc0", 32'(requests), 32'h6);
    applyStimulus(1'b0, 2'd0, 32'd0, 3'b000);
    checkNoPop("idle");
    checkOutput("hold_flit_out", flit_out, 32'hA0);

    // Fill VC1, overflow it, then drain on consecutive cycles
    applyStimulus(1'b1, 2'd1, 32'h11, 3'b000);
    applyStimulus(1'b1, 2'd1, 32'h12, 3'b000);
    applyStimulus(1'b1, 2'd1, 32'h13, 3'b000);
    applyStimulus(1'b1, 2'd1, 32'hFF, 3'b000);
`ifdef VC_BUF_OVERFLOW_CHECK_EN
    checkOutput("overflow_error", 32'(error), 32'd1);
`endif
    applyStimulus(1'b0, 2'd0, 32'd0, 3'b010);
    checkPop("drain0", 2'd1, 32'hB1);
    applyStimulus(1'b0, 2'd0, 32'd0, 3'b010);
    checkPop("drain1", 2'd1, 32'h11);
    applyStimulus(1'b0, 2'd0, 32'd0, 3'b010);
    checkPop("drain2", 2'd1, 32'h12);
    checkOutput("req_vc1_last", 32'(requests), 32'h6);
    applyStimulus(1'b0, 2'd0, 32'd0, 3'b010);
    checkPop("drain3", 2'd1, 32'h13);
    checkOutput("req_vc1_empty", 32'(requests), 32'h4);
    applyStimulus(1'b0, 2'd0, 32'd0, 3'b010);
    checkNoPop("vc1_dropped_ff");

    // Pointer wrap on VC2
    applyStimulus(1'b0, 2'd0, 32'd0, 3'b100);
    checkPop("pop_c2", 2'd2, 32'hC2);
    checkOutput("req_vc2_empty", 32'(requests), 32'h0);
    for (int r = 0; r < 5; r++) begin
      applyStimulus(1'b1, 2'd2, 32'hD0 + 32'(2 * r), 3'b000);
      applyStimulus(1'b1, 2'd2, 32'hD1 + 32'(2 * r), 3'b000);
      checkOutput("wrap_req", 32'(requests), 32'h4);
      applyStimulus(1'b0, 2'd0, 32'd0, 3'b100);
      checkPop("wrap_a", 2'd2, 32'hD0 + 32'(2 * r));
      applyStimulus(1'b0, 2'd0, 32'd0, 3'b100);
      checkPop("wrap_b", 2'd2, 32'hD1 + 32'(2 * r));
      checkOutput("wrap_req_empty", 32'(requests), 32'h0);
    end

    // Same-cycle push and pop on VC0 holding one flit
    applyStimulus(1'b1, 2'd0, 32'hE0, 3'b000);
    applyStimulus(1'b1, 2'd0, 32'hE1, 3'b001);
    checkPop("pushpop_old", 2'd0, 32'hE0);
    checkOutput("pushpop_req", 32'(requests), 32'h1);
    applyStimulus(1'b0, 2'd0, 32'd0, 3'b001);
    checkPop("pushpop_new", 2'd0, 32'hE1);
    checkOutput("pushpop_req_empty", 32'(requests), 32'h0);

    // Grant to empty VC and push to an out-of-range VC are both ignored
    applyStimulus(1'b0, 2'd0, 32'd0, 3'b100);
    checkNoPop("grant_empty");
    applyStimulus(1'b1, 2'd3, 32'h77, 3'b000);
    checkOutput("bad_vc_req", 32'(requests), 32'h0);

    // Reset in the middle of traffic
    applyStimulus(1'b1, 2'd0, 32'h30, 3'b000);
    applyStimulus(1'b1, 2'd0, 32'h31, 3'b000);
    applyStimulus(1'b1, 2'd1, 32'h40, 3'b000);
    applyStimulus(1'b1, 2'd1, 32'h41, 3'b000);
    applyStimulus(1'b1, 2'd2, 32'h50, 3'b000);
    applyStimulus(1'b1, 2'd2, 32'h51, 3'b000);
    applyStimulus(1'b1, 2'd2, 32'h52, 3'b000);
    applyStimulus(1'b0, 2'd0, 32'd0, 3'b100);
    checkPop("pre_reset", 2'd2, 32'h50);
    checkOutput("pre_reset_req", 32'(requests), 32'h7);
    reset = 1'b1;
    applyStimulus(1'b0, 2'd0, 32'd0, 3'b000);
    reset = 1'b0;
    checkOutput("mid_rst_req", 32'(requests), 32'h0);
    checkOutput("mid_rst_flit", flit_out, 32'h0);
    checkOutput("mid_rst_vc", 32'(flit_out_vc), 32'h0);
    checkOutput("mid_rst_cvc", 32'(credit_out_vc), 32'h0);
    checkNoPop("mid_rst");
`ifdef VC_BUF_OVERFLOW_CHECK_EN
    checkOutput("mid_rst_error", 32'(error), 32'd0);
`endif

    // Normal operation after reset, then a two-hot grant
    applyStimulus(1'b1, 2'd2, 32'h55, 3'b000);
    applyStimulus(1'b0, 2'd0, 32'd0, 3'b100);
    checkPop("post_rst", 2'd2, 32'h55);
    applyStimulus(1'b1, 2'd0, 32'hF0, 3'b000);
    applyStimulus(1'b1, 2'd1, 32'hF1, 3'b000);
    applyStimulus(1'b0, 2'd0, 32'd0, 3'b011);
    checkNoPop("twohot");
    checkOutput("twohot_req", 32'(requests), 32'h3);
`ifdef VC_BUF_OVERFLOW_CHECK_EN
    checkOutput("twohot_error", 32'(error), 32'd1);
`endif
    applyStimulus(1'b0, 2'd0, 32'd0, 3'b010);
    checkPop("after_twohot", 2'd1, 32'hF1);
    checkOutput("final_req", 32'(requests), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vc_input_buffer.md
Name: vc_input_buffer

Overview:
Per-input-port virtual-channel buffer that sits directly upstream of arbiter_matrix.
- Holds NUM_VCS independent flit FIFOs.
- Presents a one-bit request per non-empty VC to the arbiter.
- On a one-hot grant, pops the granted VC, registers the flit onto the output, and returns one credit upstream.

Parameters:
NUM_VCS, 3, number of virtual channels; equals arbiter NUM_REQS.
BUF_DEPTH, 4, flits per VC FIFO; power of two, >= 2.
FLIT_WIDTH, 32, flit payload width in bits.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
flit_in_valid  input  1  write strobe for flit_in.
flit_in_vc  input  $clog2(NUM_VCS)  target VC of the incoming flit.
flit_in  input  FLIT_WIDTH  incoming flit payload.
requests  output  NUM_VCS  bit v = VC v non-empty; drives arbiter requests.
grants  input  NUM_VCS  one-hot (or zero) grant from the arbiter.
flit_out_valid  output  1  registered; high for one cycle per pop.
flit_out_vc  output  $clog2(NUM_VCS)  VC index of flit_out.
flit_out  output  FLIT_WIDTH  registered popped flit.
credit_out_valid  output  1  registered; one credit returned upstream.
credit_out_vc  output  $clog2(NUM_VCS)  VC whose slot was freed.

Behaviour:
- Reset (synchronous, active-high; any cycle, including mid-traffic):
  - All rd_ptr, wr_ptr and count values go to 0.
  - requests=0, flit_out_valid=0, flit_out_vc=0, flit_out=0, credit_out_valid=0, credit_out_vc=0.
  - Buffered contents are discarded; payload RAM is not cleared.
- Per-VC state:
  - wr_ptr and rd_ptr, each $clog2(BUF_DEPTH) bits; wrap naturally modulo BUF_DEPTH.
  - count, $clog2(BUF_DEPTH+1) bits.
- requests[v] = (count[v] != 0). Combinational from registered state only, so there is no path from grants to requests.
- Push:
  - Condition: flit_in_valid and flit_in_vc < NUM_VCS and count[flit_in_vc] < BUF_DEPTH, all evaluated on pre-edge count.
  - Action: writes mem[vc][wr_ptr], then increments wr_ptr and count.
  - A push to a full VC is dropped, even if the same VC is popped that cycle. Upstream credit flow control guarantees this never occurs legally.
- Pop:
  - Condition: grants is exactly one-hot at bit g and count[g] != 0.
  - Action: reads mem[g][rd_ptr] and increments rd_ptr. On the next edge, flit_out=<that flit>, flit_out_vc=g, flit_out_valid=1.
  - Latency: grant cycle N gives flit_out_valid at cycle N+1.
- Ignored grants:
  - A grant to an empty VC is ignored: no pop, no credit.
  - grants=0 or a non-one-hot grant is ignored: no pop.
- Simultaneous push and pop on the same non-full VC:
  - Both take effect; count is unchanged.
  - A pop from a VC holding one flit plus a same-cycle push to it returns the old flit. The new flit remains, and requests[v] stays 1.
- Credit: credit_out_valid/credit_out_vc are asserted in the same cycle as flit_out_valid/flit_out_vc, exactly once per successful pop.
- Back-to-back pops:
  - A VC holding one flit and granted in cycle N shows requests[v]=0 in cycle N+1.
  - A VC holding k flits can be popped on k consecutive cycles.
- flit_out_valid=0 in any cycle with no successful pop; flit_out holds its last value.

Optional Feature:
VC_BUF_OVERFLOW_CHECK_EN
- Defined:
  - Adds output port `error` (1 bit), reset to 0.
  - `error` is sticky-set on any dropped push (full VC or flit_in_vc >= NUM_VCS), or on any non-zero, non-one-hot grant.
  - Only reset clears it. A simulation $error is also issued.
- Undefined:
  - Port `error` and its checking logic are absent.
  - Drop and ignore behaviour is identical.

Decomposition:
- Package router_pkg:
  - FLIT_WIDTH default constant.
  - vc_idx_t typedef, logic [$clog2(NUM_VCS)-1:0].
  - flit_t typedef, logic [FLIT_WIDTH-1:0].
- Sub-module fifo_sync: one VC FIFO with push, pop, full, empty, count and rd_data (combinational read). Instantiated NUM_VCS times in a generate loop.
- The top level holds grant decode, output and credit registers, and the error logic.

Test Plan:
- Reset, then push 0xA0 to VC0, 0xB1 to VC1, 0xC2 to VC2 -> requests=3'b111. Grant 3'b001 -> next cycle flit_out=0xA0, flit_out_vc=0, credit_out_valid=1, credit_out_vc=0, requests=3'b110.
- Fill VC1 with 4 flits, push a 5th (0xFF) -> dropped and `error`=1 (VC_BUF_OVERFLOW_CHECK_EN). Grant VC1 four consecutive cycles -> outputs in order, then requests[1]=0.
- Pointer wrap: push/pop VC2 ten times interleaved -> FIFO order preserved and count never exceeds 4.
- Same-cycle push and pop on VC0 holding 1 flit -> old flit output, count stays 1, requests[0]=1.
- Grant 3'b100 with VC2 empty, and grant 3'b011 -> no flit_out_valid, no credit; the 3'b011 case sets `error`.
- Assert reset while VCs hold 2 flits each -> next cycle requests=0 and all outputs zero; a subsequent push and grant work normally.
